// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the serial ADC responder model.
package adc_pkg;

    localparam int DEF_DATA_W      = 12;
    localparam int DEF_CFG_W       = 6;
    localparam int DEF_CONV_CYCLES = 80;

    localparam logic [DEF_DATA_W-1:0] BIPOLAR_FLIP = 12'h800;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        READY   = 2'd2,
        SHIFT   = 2'd3
    } adc_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with single-cycle rise/fall pulses on the synced level.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/adc_responder.sv
// Device end of the dual-lane serial ADC link: converts on CNVST, shifts results
// out MSB first on two lanes, and captures the configuration word from SD.
module adc_responder
    import adc_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CFG_W       = DEF_CFG_W,
    parameter int CONV_CYCLES = DEF_CONV_CYCLES
) (
    input  logic              clock_50MHz,
    input  logic              rst,
    input  logic              adc_cnvst,
    input  logic              adc_cs_n,
    input  logic              adc_sclk,
    input  logic              adc_sd,
    input  logic              adc_ub,
    input  logic              adc_sel,
    input  logic              adc_refsel,
    input  logic [DATA_W-1:0] sample0,
    input  logic [DATA_W-1:0] sample1,
    output logic [1:0]        adc_dout,
    output logic              conv_busy,
    output logic [CFG_W-1:0]  cfg_word,
    output logic              cfg_valid,
    output logic              frame_err
);

    localparam int CNT_W  = $clog2(CONV_CYCLES);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int RCNT_W = $clog2(CFG_W + 1);
    localparam logic [DATA_W-1:0] FLIP = DATA_W'(BIPOLAR_FLIP);

    logic cnvst_rise, cnvst_lvl_unused, cnvst_fall_unused;
    logic cs_rise, cs_fall, cs_lvl_unused;
    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic sd_meta_q, sd_sync_q;

    sync_edge #(.RST_VAL(1'b0)) u_sync_cnvst (
        .clk_i (clock_50MHz),
        .rst_i (rst),
        .d_i   (adc_cnvst),
        .sync_o(cnvst_lvl_unused),
        .rise_o(cnvst_rise),
        .fall_o(cnvst_fall_unused)
    );

    sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk_i (clock_50MHz),
        .rst_i (rst),
        .d_i   (adc_cs_n),
        .sync_o(cs_lvl_unused),
        .rise_o(cs_rise),
        .fall_o(cs_fall)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk_i (clock_50MHz),
        .rst_i (rst),
        .d_i   (adc_sclk),
        .sync_o(sclk_lvl_unused),
        .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );

    always_ff @(posedge clock_50MHz or posedge rst) begin
        if (rst) begin
            sd_meta_q <= 1'b0;
            sd_sync_q <= 1'b0;
        end else begin
            sd_meta_q <= adc_sd;
            sd_sync_q <= sd_meta_q;
        end
    end

    adc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] pend0_q, pend0_d, pend1_q, pend1_d;
    logic [DATA_W-1:0] res0_q, res0_d, res1_q, res1_d;
    logic [DATA_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [CFG_W-1:0]  cfg_sh_q, cfg_sh_d;
    logic [RCNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic [CFG_W-1:0]  cfg_word_q, cfg_word_d;
    logic              cfg_valid_q, cfg_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              refsel_unused_q, refsel_unused_d;
    logic              conv_start, frame_start;

    always_ff @(posedge clock_50MHz or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            pend0_q         <= '0;
            pend1_q         <= '0;
            res0_q          <= '0;
            res1_q          <= '0;
            sh0_q           <= '0;
            sh1_q           <= '0;
            bitcnt_q        <= '0;
            cfg_sh_q        <= '0;
            rise_cnt_q      <= '0;
            cfg_word_q      <= '0;
            cfg_valid_q     <= 1'b0;
            frame_err_q     <= 1'b0;
            refsel_unused_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pend0_q         <= pend0_d;
            pend1_q         <= pend1_d;
            res0_q          <= res0_d;
            res1_q          <= res1_d;
            sh0_q           <= sh0_d;
            sh1_q           <= sh1_d;
            bitcnt_q        <= bitcnt_d;
            cfg_sh_q        <= cfg_sh_d;
            rise_cnt_q      <= rise_cnt_d;
            cfg_word_q      <= cfg_word_d;
            cfg_valid_q     <= cfg_valid_d;
            frame_err_q     <= frame_err_d;
            refsel_unused_q <= refsel_unused_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pend0_d         = pend0_q;
        pend1_d         = pend1_q;
        res0_d          = res0_q;
        res1_d          = res1_q;
        sh0_d           = sh0_q;
        sh1_d           = sh1_q;
        bitcnt_d        = bitcnt_q;
        cfg_sh_d        = cfg_sh_q;
        rise_cnt_d      = rise_cnt_q;
        cfg_word_d      = cfg_word_q;
        cfg_valid_d     = 1'b0;
        frame_err_d     = 1'b0;
        refsel_unused_d = refsel_unused_q;
        conv_start      = 1'b0;
        frame_start     = 1'b0;

        case (state_q)
            IDLE, READY: begin
                if (cnvst_rise) begin
                    conv_start = 1'b1;
                end else if (cs_fall) begin
                    frame_start = 1'b1;
                end
            end
            CONVERT: begin
                if (cnvst_rise) begin
                    frame_err_d = 1'b1;
                end
                // Early read serves the published results and abandons the pending conversion.
                if (cs_fall) begin
                    frame_err_d = 1'b1;
                    frame_start = 1'b1;
                end else if (cnt_q == '0) begin
                    res0_d  = pend0_q;
                    res1_d  = pend1_q;
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (cnvst_rise) begin
                    frame_err_d = 1'b1;
                end
                if (cs_rise) begin
                    state_d = IDLE;
                    if (rise_cnt_q < RCNT_W'(CFG_W)) begin
                        frame_err_d = 1'b1;
                    end else begin
                        cfg_word_d  = cfg_sh_q;
                        cfg_valid_d = 1'b1;
                    end
                end else begin
                    // Once every bit has left, the lanes are already all zeros.
                    if (sclk_fall && (bitcnt_q < BIT_W'(DATA_W))) begin
                        sh0_d    = {sh0_q[DATA_W-2:0], 1'b0};
                        sh1_d    = {sh1_q[DATA_W-2:0], 1'b0};
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                    if (sclk_rise && (rise_cnt_q < RCNT_W'(CFG_W))) begin
                        cfg_sh_d   = {cfg_sh_q[CFG_W-2:0], sd_sync_q};
                        rise_cnt_d = rise_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (conv_start) begin
            pend0_d         = adc_ub ? sample0 : (sample0 ^ FLIP);
            pend1_d         = adc_ub ? sample1 : (sample1 ^ FLIP);
            cnt_d           = CNT_W'(CONV_CYCLES - 1);
            refsel_unused_d = adc_refsel;
            state_d         = CONVERT;
        end
        if (frame_start) begin
            sh0_d      = adc_sel ? res1_q : res0_q;
            sh1_d      = adc_sel ? res0_q : res1_q;
            bitcnt_d   = '0;
            cfg_sh_d   = '0;
            rise_cnt_d = '0;
            state_d    = SHIFT;
        end
    end

    assign adc_dout  = (state_q == SHIFT) ? {sh1_q[DATA_W-1], sh0_q[DATA_W-1]} : 2'b00;
    assign conv_busy = (state_q == CONVERT);
    assign cfg_word  = cfg_word_q;
    assign cfg_valid = cfg_valid_q;
    assign frame_err = frame_err_q;

endmodule
